ram_arbiter: RTL

//   Shares the single RAM data port between two requesters: port 0 (core data side)
//   and port 1 (DMA / debug loader).

---
 rtl/arb_pkg.sv | 22 ++
 rtl/ram_arbiter_rr.sv | 31 +++
 rtl/ram_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types for the two-port RAM arbiter.
// Optional feature macro: ARB_BOUNDS_CHECK_EN (see ram_arbiter.sv).
package arb_pkg;

    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DATA_W = 32;
    localparam int BE_W       = CMD_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef struct packed {
        logic [BE_W-1:0]       we;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
        logic                  port;
    } arb_cmd_t;

endpackage

// File: rtl/ram_arbiter_rr.sv
// Two-way request picker: fixed priority to port 0 or round-robin.
// Owns the round-robin pointer (0 = port 0 wins the next tie).
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       prio_fixed,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr;

    // Pick a single winner; a lone requester always wins.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (prio_fixed || !ptr) ? 2'b01 : 2'b10;
        end
    end

    // After each grant the pointer favours the port that lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM data port between port 0 (core) and port 1 (DMA/debug).
// Define ARB_BOUNDS_CHECK_EN to reject out-of-range words with mN_err.
module ram_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RAM_WORDS  = 4194304,
    parameter int PRIO_FIXED = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req,
    input  logic [DATA_W/8-1:0] m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic                m0_ready,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_err,
    input  logic                m1_req,
    input  logic [DATA_W/8-1:0] m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic                m1_ready,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_err,
    output logic                ram_r,
    output logic [DATA_W/8-1:0] ram_w,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_out,
    input  logic [DATA_W-1:0]   ram_in
);

    arb_state_t            state;
    arb_cmd_t              cmd;
    logic [1:0]            grant;
    logic [1:0]            rvalid_q;
    logic                  idle;
    logic                  accept;
    logic                  bad;
    logic [DATA_W/8-1:0]   sel_we;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_wdata;

    // Nothing is granted while reset is held, even with req high.
    assign idle   = (state == IDLE) && !rst;
    assign accept = idle && (grant != 2'b00);

    rr_arbiter2 u_pick (
        .clk        (clk),
        .rst        (rst),
        .req        ({m1_req, m0_req}),
        .prio_fixed (PRIO_FIXED != 0),
        .advance    (accept),
        .grant      (grant)
    );

    assign sel_we    = grant[1] ? m1_we    : m0_we;
    assign sel_addr  = grant[1] ? m1_addr  : m0_addr;
    assign sel_wdata = grant[1] ? m1_wdata : m0_wdata;

`ifdef ARB_BOUNDS_CHECK_EN
    assign bad = {2'b00, sel_addr[ADDR_W-1:2]} >= ADDR_W'(RAM_WORDS);
`else
    assign bad = 1'b0;
`endif

    assign m0_ready = accept & grant[0];
    assign m1_ready = accept & grant[1];
    assign m0_err   = accept & bad & grant[0];
    assign m1_err   = accept & bad & grant[1];

    // Address and data hold the last accepted command.
    assign ram_addr = cmd.addr;
    assign ram_out  = cmd.wdata;

    // RAM data is only passed to the owning port during RESP.
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_rdata  = rvalid_q[0] ? ram_in : '0;
    assign m1_rdata  = rvalid_q[1] ? ram_in : '0;

    // Transaction FSM: latch the winner, strobe RAM, then steer read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cmd      <= '0;
            ram_r    <= 1'b0;
            ram_w    <= '0;
            rvalid_q <= 2'b00;
        end else begin
            ram_r    <= 1'b0;
            ram_w    <= '0;
            rvalid_q <= 2'b00;
            unique case (state)
                IDLE: begin
                    if (accept && !bad) begin
                        cmd.we    <= sel_we;
                        cmd.addr  <= sel_addr;
                        cmd.wdata <= sel_wdata;
                        cmd.port  <= grant[1];
                        ram_w     <= sel_we;
                        ram_r     <= (sel_we == '0);
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cmd.we == '0) begin
                        rvalid_q <= cmd.port ? 2'b10 : 2'b01;
                        state    <= RESP;
                    end else begin
                        state <= IDLE;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
